// File: rtl/rv32i_ctrl_pkg.sv
// Shared encodings for the RV32I main decoder: opcodes, selector enums and the
// packed control word carried in the decode->execute register.
package rv32i_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I_ALU  = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_LUI    = 7'h37;

  typedef enum logic [1:0] {
    A_RS1  = 2'b00,
    A_PC   = 2'b01,
    A_ZERO = 2'b10,
    A_RSVD = 2'b11
  } a_sel_e;

  typedef enum logic [1:0] {
    IMM_I  = 2'b00,
    IMM_S  = 2'b01,
    IMM_B  = 2'b10,
    IMM_UJ = 2'b11
  } imm_sel_e;

  typedef enum logic [1:0] {
    NPC_PLUS4  = 2'b00,
    NPC_BRANCH = 2'b01,
    NPC_ALU    = 2'b10,
    NPC_RSVD   = 2'b11
  } npc_sel_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_e;

  // alu_op stays a plain vector: the permissive build passes {f7b6,f3}
  // through unchanged, which can produce codes outside alu_op_e.
  typedef struct packed {
    logic       write;
    logic       store;
    logic       load;
    logic       branch;
    a_sel_e     a_sel;
    logic       b_sel;
    imm_sel_e   imm_sel;
    npc_sel_e   npc_sel;
    logic [3:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/rv32i_control_unit_if.sv
// Instruction-field inputs and registered control outputs of the RV32I decoder.
// master = fetch/datapath side, slave = control unit.
interface rv32i_control_unit_if;

  logic [6:0] opcode;
  logic       func_7_bit_6;
  logic [2:0] func_3;
  logic       write;
  logic       store;
  logic       load;
  logic       branch;
  logic [1:0] alu_operand_a_selector;
  logic       alu_operand_b_selector;
  logic [1:0] immediate_selector;
  logic [1:0] next_pc_selector;
  logic [3:0] alu_operations_selector;

  modport master (
    output opcode, func_7_bit_6, func_3,
    input  write, store, load, branch, alu_operand_a_selector, alu_operand_b_selector,
    input  immediate_selector, next_pc_selector, alu_operations_selector
  );

  modport slave (
    input  opcode, func_7_bit_6, func_3,
    output write, store, load, branch, alu_operand_a_selector, alu_operand_b_selector,
    output immediate_selector, next_pc_selector, alu_operations_selector
  );

endinterface

// File: rtl/rv32i_ctrl_decode.sv
// Purely combinational RV32I opcode decoder producing a ctrl_t word.
// Optional CU_STRICT_DECODE_EN turns illegal func_3/func_7 sub-encodings into NOPs.
module rv32i_ctrl_decode
  import rv32i_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic       func_7_bit_6,
  input  logic [2:0] func_3,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_R: begin
        ctrl.write  = 1'b1;
        ctrl.alu_op = {func_7_bit_6, func_3};
`ifdef CU_STRICT_DECODE_EN
        if (func_7_bit_6 && (func_3 != 3'b000) && (func_3 != 3'b101)) ctrl = '0;
`endif
      end
      OP_I_ALU: begin
        ctrl.write  = 1'b1;
        ctrl.b_sel  = 1'b1;
        // Only SRAI borrows instruction[30]; for other I-ALU ops it is immediate data.
        ctrl.alu_op = {func_7_bit_6 && (func_3 == 3'b101), func_3};
`ifdef CU_STRICT_DECODE_EN
        if (func_7_bit_6 && (func_3 == 3'b001)) ctrl = '0;
`endif
      end
      OP_LOAD: begin
        ctrl.write = 1'b1;
        ctrl.load  = 1'b1;
        ctrl.b_sel = 1'b1;
`ifdef CU_STRICT_DECODE_EN
        if ((func_3 == 3'd3) || (func_3 == 3'd6) || (func_3 == 3'd7)) ctrl = '0;
`endif
      end
      OP_STORE: begin
        ctrl.store   = 1'b1;
        ctrl.b_sel   = 1'b1;
        ctrl.imm_sel = IMM_S;
`ifdef CU_STRICT_DECODE_EN
        if (func_3 >= 3'd3) ctrl = '0;
`endif
      end
      OP_BRANCH: begin
        ctrl.branch  = 1'b1;
        ctrl.a_sel   = A_PC;
        ctrl.b_sel   = 1'b1;
        ctrl.imm_sel = IMM_B;
        ctrl.npc_sel = NPC_BRANCH;
`ifdef CU_STRICT_DECODE_EN
        if ((func_3 == 3'd2) || (func_3 == 3'd3)) ctrl = '0;
`endif
      end
      OP_JALR: begin
        ctrl.write   = 1'b1;
        ctrl.b_sel   = 1'b1;
        ctrl.npc_sel = NPC_ALU;
`ifdef CU_STRICT_DECODE_EN
        if (func_3 != 3'd0) ctrl = '0;
`endif
      end
      OP_JAL: begin
        ctrl.write   = 1'b1;
        ctrl.a_sel   = A_PC;
        ctrl.b_sel   = 1'b1;
        ctrl.imm_sel = IMM_UJ;
        ctrl.npc_sel = NPC_ALU;
      end
      OP_AUIPC: begin
        ctrl.write   = 1'b1;
        ctrl.a_sel   = A_PC;
        ctrl.b_sel   = 1'b1;
        ctrl.imm_sel = IMM_UJ;
      end
      OP_LUI: begin
        ctrl.write   = 1'b1;
        ctrl.a_sel   = A_ZERO;
        ctrl.b_sel   = 1'b1;
        ctrl.imm_sel = IMM_UJ;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/rv32i_control_unit.sv
// RV32I main control unit: decode registered into the decode->execute stage, 1-cycle latency.
// Build option: CU_STRICT_DECODE_EN (strict sub-encoding checks inside rv32i_ctrl_decode).
module rv32i_control_unit
  import rv32i_ctrl_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  rv32i_control_unit_if.slave        bus
);

  ctrl_t ctrl_next;
  ctrl_t ctrl_reg;

  rv32i_ctrl_decode u_decode (
    .opcode       (bus.opcode),
    .func_7_bit_6 (bus.func_7_bit_6),
    .func_3       (bus.func_3),
    .ctrl         (ctrl_next)
  );

  always_ff @(posedge clk) begin
    if (rst) ctrl_reg <= '0;
    else     ctrl_reg <= ctrl_next;
  end

  assign bus.write                   = ctrl_reg.write;
  assign bus.store                   = ctrl_reg.store;
  assign bus.load                    = ctrl_reg.load;
  assign bus.branch                  = ctrl_reg.branch;
  assign bus.alu_operand_a_selector  = ctrl_reg.a_sel;
  assign bus.alu_operand_b_selector  = ctrl_reg.b_sel;
  assign bus.immediate_selector      = ctrl_reg.imm_sel;
  assign bus.next_pc_selector        = ctrl_reg.npc_sel;
  assign bus.alu_operations_selector = ctrl_reg.alu_op;

endmodule

// File: tb/tb_rv32i_control_unit.sv
// Table-driven, scoreboarded bench for rv32i_control_unit (both CU_STRICT_DECODE_EN builds).
module tb_rv32i_control_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv32i_control_unit_if cu_if ();

  rv32i_control_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (cu_if)
  );

  // Output bundle: {write,store,load,branch,a[1:0],b,imm[1:0],npc[1:0],alu[3:0]}
  typedef logic [14:0] out_t;

  typedef struct {
    string      name;
    logic       rst;
    logic [6:0] op;
    logic       f7;
    logic [2:0] f3;
    out_t       exp;
  } vec_t;

  localparam out_t NOP = 15'd0;

  int   checks = 0;
  int   errors = 0;
  out_t exp_q[$];
  string name_q[$];
  vec_t vecs[$];

  function automatic out_t mk(input logic w, input logic s, input logic l, input logic br,
                              input logic [1:0] a, input logic b, input logic [1:0] imm,
                              input logic [1:0] npc, input logic [3:0] alu);
    return {w, s, l, br, a, b, imm, npc, alu};
  endfunction

  function automatic vec_t v(input string n, input logic r, input logic [6:0] op,
                             input logic f7, input logic [2:0] f3, input out_t e);
    vec_t t;
    t.name = n; t.rst = r; t.op = op; t.f7 = f7; t.f3 = f3; t.exp = e;
    return t;
  endfunction

  function automatic out_t sample();
    return {cu_if.write, cu_if.store, cu_if.load, cu_if.branch, cu_if.alu_operand_a_selector,
            cu_if.alu_operand_b_selector, cu_if.immediate_selector, cu_if.next_pc_selector,
            cu_if.alu_operations_selector};
  endfunction

  task automatic apply(input vec_t t);
    out_t  act;
    out_t  e;
    string n;
    @(negedge clk);
    rst = t.rst;
    cu_if.opcode = t.op;
    cu_if.func_7_bit_6 = t.f7;
    cu_if.func_3 = t.f3;
    exp_q.push_back(t.exp);
    name_q.push_back(t.name);
    @(posedge clk);
    #1;
    act = sample();
    e = exp_q.pop_front();
    n = name_q.pop_front();
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %b required %b", n, act, e);
    end else begin
      $display("txn %-14s op=%h f7=%b f3=%b rst=%b out=%b ok", n, t.op, t.f7, t.f3, t.rst, act);
    end
  endtask

  out_t r_sub, strict_or_ld, strict_or_st, strict_or_br, strict_or_jalr, strict_or_r, strict_or_i;

  initial begin
    cu_if.opcode = 7'h33;
    cu_if.func_7_bit_6 = 1'b0;
    cu_if.func_3 = 3'b000;

`ifdef CU_STRICT_DECODE_EN
    strict_or_r    = NOP;
    strict_or_i    = NOP;
    strict_or_ld   = NOP;
    strict_or_st   = NOP;
    strict_or_br   = NOP;
    strict_or_jalr = NOP;
`else
    strict_or_r    = mk(1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 4'b1010);
    strict_or_i    = mk(1, 0, 0, 0, 2'b00, 1, 2'b00, 2'b00, 4'b0001);
    strict_or_ld   = mk(1, 0, 1, 0, 2'b00, 1, 2'b00, 2'b00, 4'b0000);
    strict_or_st   = mk(0, 1, 0, 0, 2'b00, 1, 2'b01, 2'b00, 4'b0000);
    strict_or_br   = mk(0, 0, 0, 1, 2'b01, 1, 2'b10, 2'b01, 4'b0000);
    strict_or_jalr = mk(1, 0, 0, 0, 2'b00, 1, 2'b00, 2'b10, 4'b0000);
`endif
    r_sub = mk(1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 4'b1000);

    // Reset held two cycles with an R-type on the bus, then release.
    vecs.push_back(v("rst_hold_0",  1, 7'h33, 1, 3'b000, NOP));
    vecs.push_back(v("rst_hold_1",  1, 7'h33, 1, 3'b000, NOP));
    vecs.push_back(v("r_sub",       0, 7'h33, 1, 3'b000, r_sub));
    vecs.push_back(v("r_sra",       0, 7'h33, 1, 3'b101, mk(1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 4'b1101)));
    vecs.push_back(v("r_and",       0, 7'h33, 0, 3'b111, mk(1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 4'b0111)));
    vecs.push_back(v("r_f7_slt",    0, 7'h33, 1, 3'b010, strict_or_r));
    vecs.push_back(v("lw",          0, 7'h03, 0, 3'b010, mk(1, 0, 1, 0, 2'b00, 1, 2'b00, 2'b00, 4'b0000)));
    vecs.push_back(v("load_f3_7",   0, 7'h03, 1, 3'b111, strict_or_ld));
    vecs.push_back(v("sw",          0, 7'h23, 0, 3'b010, mk(0, 1, 0, 0, 2'b00, 1, 2'b01, 2'b00, 4'b0000)));
    vecs.push_back(v("store_f3_3",  0, 7'h23, 0, 3'b011, strict_or_st));
    vecs.push_back(v("bne",         0, 7'h63, 1, 3'b001, mk(0, 0, 0, 1, 2'b01, 1, 2'b10, 2'b01, 4'b0000)));
    vecs.push_back(v("branch_f3_2", 0, 7'h63, 0, 3'b010, strict_or_br));
    vecs.push_back(v("jal",         0, 7'h6f, 1, 3'b101, mk(1, 0, 0, 0, 2'b01, 1, 2'b11, 2'b10, 4'b0000)));
    vecs.push_back(v("jalr",        0, 7'h67, 0, 3'b000, mk(1, 0, 0, 0, 2'b00, 1, 2'b00, 2'b10, 4'b0000)));
    vecs.push_back(v("jalr_f3_1",   0, 7'h67, 0, 3'b001, strict_or_jalr));
    vecs.push_back(v("auipc",       0, 7'h17, 1, 3'b110, mk(1, 0, 0, 0, 2'b01, 1, 2'b11, 2'b00, 4'b0000)));
    vecs.push_back(v("lui",         0, 7'h37, 0, 3'b011, mk(1, 0, 0, 0, 2'b10, 1, 2'b11, 2'b00, 4'b0000)));
    vecs.push_back(v("addi_f7",     0, 7'h13, 1, 3'b000, mk(1, 0, 0, 0, 2'b00, 1, 2'b00, 2'b00, 4'b0000)));
    vecs.push_back(v("srai",        0, 7'h13, 1, 3'b101, mk(1, 0, 0, 0, 2'b00, 1, 2'b00, 2'b00, 4'b1101)));
    vecs.push_back(v("srli",        0, 7'h13, 0, 3'b101, mk(1, 0, 0, 0, 2'b00, 1, 2'b00, 2'b00, 4'b0101)));
    vecs.push_back(v("andi_f7",     0, 7'h13, 1, 3'b111, mk(1, 0, 0, 0, 2'b00, 1, 2'b00, 2'b00, 4'b0111)));
    vecs.push_back(v("slli_f7",     0, 7'h13, 1, 3'b001, strict_or_i));
    vecs.push_back(v("op_00",       0, 7'h00, 1, 3'b111, NOP));
    vecs.push_back(v("op_7f",       0, 7'h7f, 1, 3'b101, NOP));
    vecs.push_back(v("op_0f",       0, 7'h0f, 0, 3'b000, NOP));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Reset mid-stream discards the in-flight decode; next instruction decodes normally.
    apply(v("pre_mid_rst",  0, 7'h6f, 0, 3'b000, mk(1, 0, 0, 0, 2'b01, 1, 2'b11, 2'b10, 4'b0000)));
    apply(v("mid_rst",      1, 7'h63, 0, 3'b000, NOP));
    apply(v("post_rst_lui", 0, 7'h37, 0, 3'b000, mk(1, 0, 0, 0, 2'b10, 1, 2'b11, 2'b00, 4'b0000)));
    // Back-to-back opcode changes each reflect exactly one cycle later.
    apply(v("b2b_sw",       0, 7'h23, 0, 3'b000, mk(0, 1, 0, 0, 2'b00, 1, 2'b01, 2'b00, 4'b0000)));
    apply(v("b2b_nop",      0, 7'h00, 0, 3'b000, NOP));

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
